// File: rtl/aes_cipher_arbiter_pkg.sv
// rtl/aes_cipher_arbiter_pkg.sv - shared types for the two-requester AES cipher arbiter
//
// Holds the arbiter state encoding, the key-length encoding presented to the
// cipher core, and a small helper that turns a requester index into a one-hot grant.

package aes_cipher_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_KEY_SWAP = 2'd1,
        ST_SEND     = 2'd2,
        ST_RECV     = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        KEYLEN_128 = 2'b00,
        KEYLEN_192 = 2'b01,
        KEYLEN_256 = 2'b10
    } key_len_e;

    function automatic logic [1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/aes_rr_arbiter2.sv
// rtl/aes_rr_arbiter2.sv - two-way round-robin grant decision
//
// Ports:
//   req_i   [1:0]  request vector (bit N = requester N)
//   last_i         index of the requester granted most recently
//   grant_o [1:0]  one-hot grant, 00 when nothing is requested

module aes_rr_arbiter2
    import aes_cipher_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            // On a tie the requester that did not go last wins.
            2'b11:   grant_o = req_onehot(~last_i);
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/aes_cipher_arbiter.sv
// rtl/aes_cipher_arbiter.sv - shares one AES cipher core between two block requesters
//
// Optional feature macro: AES_ARB_STATS_EN (per-requester completed-block counters).
//
// Ports:
//   Clk, Rst, En                  clock, sync active-high reset, enable (low = reset)
//   ReqKeyN / ReqKeyLenN          requester key (top-aligned) and length code
//   ReqKeyUpdateN                 pulse that latches the requester key
//   sN_axis_*                     128-bit plaintext block input per requester
//   mN_axis_*                     ciphertext byte stream output per requester
//   CipherKey / CipherKeyLen      key of the current owner, to the cipher core
//   CipherKeyUpdate / ...LenUpdate one-cycle load pulses to the cipher core
//   cipher_s_axis_*               block to the cipher core
//   cipher_m_axis_*               byte stream from the cipher core
//   Grant                         one-hot current owner, 00 when idle
//   BlockCnt0 / BlockCnt1         completed blocks per requester

module aes_cipher_arbiter
    import aes_cipher_arbiter_pkg::*;
#(
    parameter int STATS_W = 32
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               En,
    input  logic [255:0]       ReqKey0,
    input  logic [255:0]       ReqKey1,
    input  logic [1:0]         ReqKeyLen0,
    input  logic [1:0]         ReqKeyLen1,
    input  logic               ReqKeyUpdate0,
    input  logic               ReqKeyUpdate1,
    input  logic [127:0]       s0_axis_tdata,
    input  logic               s0_axis_tvalid,
    output logic               s0_axis_tready,
    input  logic [127:0]       s1_axis_tdata,
    input  logic               s1_axis_tvalid,
    output logic               s1_axis_tready,
    output logic [7:0]         m0_axis_tdata,
    output logic               m0_axis_tvalid,
    input  logic               m0_axis_tready,
    output logic               m0_axis_tlast,
    output logic               m0_axis_tkeep,
    output logic [7:0]         m1_axis_tdata,
    output logic               m1_axis_tvalid,
    input  logic               m1_axis_tready,
    output logic               m1_axis_tlast,
    output logic               m1_axis_tkeep,
    output logic [255:0]       CipherKey,
    output logic [1:0]         CipherKeyLen,
    output logic               CipherKeyUpdate,
    output logic               CipherKeyLenUpdate,
    output logic [127:0]       cipher_s_axis_tdata,
    output logic               cipher_s_axis_tvalid,
    input  logic               cipher_s_axis_tready,
    input  logic [7:0]         cipher_m_axis_tdata,
    input  logic               cipher_m_axis_tvalid,
    output logic               cipher_m_axis_tready,
    input  logic               cipher_m_axis_tlast,
    output logic [1:0]         Grant,
    output logic [STATS_W-1:0] BlockCnt0,
    output logic [STATS_W-1:0] BlockCnt1
);

    logic blk_rst;
    assign blk_rst = Rst | ~En;

    arb_state_e   state_q, state_d;
    logic [1:0]   grant_q, grant_d;
    logic         last_q, last_d;
    logic         owner_q, owner_d;
    logic         owner_valid_q, owner_valid_d;
    logic [1:0]   dirty_q, dirty_d;
    logic [1:0]   dirty_clr;
    logic [255:0] key0_q, key1_q;
    logic [1:0]   keylen0_q, keylen1_q;

    logic [1:0]   arb_grant;
    logic         arb_sel;
    logic         sel;
    logic         m_last_hs;

    aes_rr_arbiter2 u_rr (
        .req_i   ({s1_axis_tvalid, s0_axis_tvalid}),
        .last_i  (last_q),
        .grant_o (arb_grant)
    );

    assign arb_sel   = arb_grant[1];
    assign sel       = grant_q[1];
    assign m_last_hs = (state_q == ST_RECV) && cipher_m_axis_tvalid
                       && cipher_m_axis_tready && cipher_m_axis_tlast;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        owner_d       = owner_q;
        owner_valid_d = owner_valid_q;
        dirty_clr     = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (arb_grant != 2'b00) begin
                    grant_d = arb_grant;
                    if ((arb_sel != owner_q) || !owner_valid_q || dirty_q[arb_sel]) begin
                        state_d = ST_KEY_SWAP;
                        // Owner moves on entry to KEY_SWAP so that CipherKey already
                        // shows the new owner's key while the load pulse is high.
                        owner_d = arb_sel;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end
            ST_KEY_SWAP: begin
                owner_valid_d = 1'b1;
                dirty_clr     = grant_q;
                state_d       = ST_SEND;
            end
            ST_SEND: begin
                if (cipher_s_axis_tready) begin
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                if (m_last_hs) begin
                    state_d = ST_IDLE;
                    grant_d = 2'b00;
                    last_d  = sel;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A key latched in the same cycle as the swap keeps the requester dirty.
        dirty_d = (dirty_q & ~dirty_clr) | {ReqKeyUpdate1, ReqKeyUpdate0};
    end

    always_ff @(posedge Clk) begin
        if (blk_rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= 2'b00;
            last_q        <= 1'b1;
            owner_q       <= 1'b0;
            owner_valid_q <= 1'b0;
            dirty_q       <= 2'b00;
            key0_q        <= '0;
            key1_q        <= '0;
            keylen0_q     <= KEYLEN_128;
            keylen1_q     <= KEYLEN_128;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_q        <= last_d;
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
            dirty_q       <= dirty_d;
            if (ReqKeyUpdate0) begin
                key0_q    <= ReqKey0;
                keylen0_q <= ReqKeyLen0;
            end
            if (ReqKeyUpdate1) begin
                key1_q    <= ReqKey1;
                keylen1_q <= ReqKeyLen1;
            end
        end
    end

    always_comb begin
        CipherKey            = owner_q ? key1_q : key0_q;
        CipherKeyLen         = owner_q ? keylen1_q : keylen0_q;
        CipherKeyUpdate      = 1'b0;
        CipherKeyLenUpdate   = 1'b0;
        cipher_s_axis_tdata  = '0;
        cipher_s_axis_tvalid = 1'b0;
        cipher_m_axis_tready = 1'b0;
        s0_axis_tready       = 1'b0;
        s1_axis_tready       = 1'b0;
        m0_axis_tdata        = '0;
        m0_axis_tvalid       = 1'b0;
        m0_axis_tlast        = 1'b0;
        m0_axis_tkeep        = 1'b0;
        m1_axis_tdata        = '0;
        m1_axis_tvalid       = 1'b0;
        m1_axis_tlast        = 1'b0;
        m1_axis_tkeep        = 1'b0;
        case (state_q)
            ST_KEY_SWAP: begin
                CipherKeyUpdate    = 1'b1;
                CipherKeyLenUpdate = 1'b1;
            end
            ST_SEND: begin
                cipher_s_axis_tvalid = 1'b1;
                cipher_s_axis_tdata  = sel ? s1_axis_tdata : s0_axis_tdata;
                s0_axis_tready       = ~sel & cipher_s_axis_tready;
                s1_axis_tready       = sel & cipher_s_axis_tready;
            end
            ST_RECV: begin
                cipher_m_axis_tready = sel ? m1_axis_tready : m0_axis_tready;
                if (sel) begin
                    m1_axis_tdata  = cipher_m_axis_tdata;
                    m1_axis_tvalid = cipher_m_axis_tvalid;
                    m1_axis_tlast  = cipher_m_axis_tlast;
                    m1_axis_tkeep  = 1'b1;
                end else begin
                    m0_axis_tdata  = cipher_m_axis_tdata;
                    m0_axis_tvalid = cipher_m_axis_tvalid;
                    m0_axis_tlast  = cipher_m_axis_tlast;
                    m0_axis_tkeep  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign Grant = grant_q;

`ifdef AES_ARB_STATS_EN
    logic [STATS_W-1:0] cnt0_q, cnt1_q;

    always_ff @(posedge Clk) begin
        if (blk_rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (m_last_hs) begin
            if (sel) begin
                cnt1_q <= cnt1_q + STATS_W'(1);
            end else begin
                cnt0_q <= cnt0_q + STATS_W'(1);
            end
        end
    end

    assign BlockCnt0 = cnt0_q;
    assign BlockCnt1 = cnt1_q;
`else
    assign BlockCnt0 = '0;
    assign BlockCnt1 = '0;
`endif

endmodule

// File: tb/tb_aes_cipher_arbiter.sv
// tb/tb_aes_cipher_arbiter.sv - scoreboard bench for the AES cipher arbiter

module tb_aes_cipher_arbiter;

    localparam int STATS_W = 32;
    localparam logic [255:0] FIPS_KEY = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic Clk = 1'b0;
    logic Rst, En;
    logic [255:0] req_key [2];
    logic [1:0]   req_len [2];
    logic         req_upd [2];
    logic [127:0] s_tdata [2];
    logic         s_tvalid [2];
    logic         s_tready [2];
    logic [7:0]   m_tdata [2];
    logic         m_tvalid [2];
    logic         m_tready [2];
    logic         m_tlast [2];
    logic         m_tkeep [2];
    logic [255:0] CipherKey;
    logic [1:0]   CipherKeyLen;
    logic         CipherKeyUpdate, CipherKeyLenUpdate;
    logic [127:0] cs_tdata;
    logic         cs_tvalid, cs_tready;
    logic [7:0]   cm_tdata;
    logic         cm_tvalid, cm_tready, cm_tlast;
    logic [1:0]   Grant;
    logic [STATS_W-1:0] BlockCnt0, BlockCnt1;

    aes_cipher_arbiter #(.STATS_W(STATS_W)) dut (
        .Clk(Clk), .Rst(Rst), .En(En),
        .ReqKey0(req_key[0]), .ReqKey1(req_key[1]),
        .ReqKeyLen0(req_len[0]), .ReqKeyLen1(req_len[1]),
        .ReqKeyUpdate0(req_upd[0]), .ReqKeyUpdate1(req_upd[1]),
        .s0_axis_tdata(s_tdata[0]), .s0_axis_tvalid(s_tvalid[0]), .s0_axis_tready(s_tready[0]),
        .s1_axis_tdata(s_tdata[1]), .s1_axis_tvalid(s_tvalid[1]), .s1_axis_tready(s_tready[1]),
        .m0_axis_tdata(m_tdata[0]), .m0_axis_tvalid(m_tvalid[0]), .m0_axis_tready(m_tready[0]),
        .m0_axis_tlast(m_tlast[0]), .m0_axis_tkeep(m_tkeep[0]),
        .m1_axis_tdata(m_tdata[1]), .m1_axis_tvalid(m_tvalid[1]), .m1_axis_tready(m_tready[1]),
        .m1_axis_tlast(m_tlast[1]), .m1_axis_tkeep(m_tkeep[1]),
        .CipherKey(CipherKey), .CipherKeyLen(CipherKeyLen),
        .CipherKeyUpdate(CipherKeyUpdate), .CipherKeyLenUpdate(CipherKeyLenUpdate),
        .cipher_s_axis_tdata(cs_tdata), .cipher_s_axis_tvalid(cs_tvalid), .cipher_s_axis_tready(cs_tready),
        .cipher_m_axis_tdata(cm_tdata), .cipher_m_axis_tvalid(cm_tvalid), .cipher_m_axis_tready(cm_tready),
        .cipher_m_axis_tlast(cm_tlast),
        .Grant(Grant), .BlockCnt0(BlockCnt0), .BlockCnt1(BlockCnt1)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int upd_cnt = 0;
    int idx [2];
    int done [2];
    int last_cyc [2];
    logic [127:0] exp_q [2][$];
    logic [1:0]   grant_log [$];
    logic [255:0] mkey [2];
    logic [1:0]   mlen [2];
    logic         rand_ready = 1'b0;

    logic         core_busy;
    int           core_cnt;
    logic [127:0] core_blk;
    logic [255:0] ckey;
    logic [1:0]   clen;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stand-in cipher: reproduces the FIPS-197 vector exactly, otherwise a key-dependent mix.
    function automatic logic [127:0] ref_cipher(input logic [255:0] k, input logic [1:0] l,
                                                input logic [127:0] p);
        if (k == FIPS_KEY && l == 2'b00 && p == FIPS_PT) return FIPS_CT;
        return {p[63:0], p[127:64]} ^ k[255:128] ^ k[127:0] ^ {126'd0, l};
    endfunction

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [255:0] exp_cnt(input int n);
`ifdef AES_ARB_STATS_EN
        return 256'(n);
`else
        return 256'(0 * n);
`endif
    endfunction

    function automatic logic [1:0] oh(input int r);
        return (r == 1) ? 2'b10 : 2'b01;
    endfunction

    initial forever begin
        @(posedge Clk);
        cyc++;
    end

    // Behavioural cipher core: loads its key on the update pulse, emits 16 bytes MSB first.
    initial begin
        cs_tready = 1'b0; cm_tvalid = 1'b0; cm_tdata = '0; cm_tlast = 1'b0;
        core_busy = 1'b0; core_cnt = 0; core_blk = '0; ckey = '0; clen = '0;
        forever begin
            @(negedge Clk);
            if (Rst || !En) begin
                core_busy = 1'b0; core_cnt = 0; ckey = '0; clen = '0;
            end else begin
                if (CipherKeyUpdate) begin
                    ckey = CipherKey;
                    clen = CipherKeyLen;
                    upd_cnt++;
                    check("keylen_update_paired", 256'(CipherKeyLenUpdate), 256'(1));
                end
                if (!core_busy && cs_tvalid && cs_tready) begin
                    core_blk  = ref_cipher(ckey, clen, cs_tdata);
                    core_busy = 1'b1;
                    core_cnt  = 0;
                    grant_log.push_back(Grant);
                end else if (core_busy && cm_tvalid && cm_tready) begin
                    core_cnt++;
                    if (core_cnt == 16) core_busy = 1'b0;
                end
            end
            @(posedge Clk); #1;
            cs_tready = !core_busy && ($urandom_range(0, 3) != 0);
            cm_tvalid = core_busy;
            cm_tdata  = core_busy ? core_blk[127 - 8 * core_cnt -: 8] : 8'h00;
            cm_tlast  = core_busy && (core_cnt == 15);
        end
    end

    initial begin
        m_tready[0] = 1'b1; m_tready[1] = 1'b1;
        forever begin
            @(posedge Clk); #1;
            m_tready[0] = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            m_tready[1] = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops expected bytes per output port and checks routing invariants.
    initial begin
        logic [127:0] fb;
        for (int r = 0; r < 2; r++) begin idx[r] = 0; done[r] = 0; last_cyc[r] = 0; end
        forever begin
            @(negedge Clk);
            if (Rst || !En) begin
                for (int r = 0; r < 2; r++) begin
                    exp_q[r].delete(); idx[r] = 0; done[r] = 0;
                end
            end else begin
                for (int r = 0; r < 2; r++) begin
                    if (s_tready[r])
                        check("s_tready_only_in_own_send", 256'({cs_tvalid, Grant}), 256'({1'b1, oh(r)}));
                    if (m_tvalid[r]) begin
                        check("m_routed_to_owner", 256'(Grant), 256'(oh(r)));
                        check("m_tkeep", 256'(m_tkeep[r]), 256'(1));
                        if (m_tready[r]) begin
                            if (exp_q[r].size() == 0) begin
                                total++; bad++;
                                $display("FAIL m%0d_extra_byte: got %0h expected none", r, m_tdata[r]);
                            end else begin
                                fb = exp_q[r][0];
                                check("m_byte", 256'(m_tdata[r]), 256'(fb[127 - 8 * idx[r] -: 8]));
                                check("m_tlast", 256'(m_tlast[r]), 256'(idx[r] == 15));
                                idx[r]++;
                                if (idx[r] == 16) begin
                                    void'(exp_q[r].pop_front());
                                    idx[r] = 0;
                                    done[r]++;
                                    last_cyc[r] = cyc;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    // All driver tasks are entered and left just after a rising edge.
    task automatic key_update(input int r, input logic [255:0] k, input logic [1:0] l);
        req_key[r] = k; req_len[r] = l; req_upd[r] = 1'b1;
        mkey[r] = k; mlen[r] = l;
        @(posedge Clk); #1;
        req_upd[r] = 1'b0;
    endtask

    task automatic send_block(input int r, input logic [127:0] d, output int acc);
        bit ok = 0;
        exp_q[r].push_back(ref_cipher(mkey[r], mlen[r], d));
        s_tdata[r] = d; s_tvalid[r] = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge Clk);
            if (s_tready[r]) begin ok = 1; break; end
        end
        @(posedge Clk); #1;
        s_tvalid[r] = 1'b0;
        acc = cyc;
        if (!ok) begin
            total++; bad++;
            $display("FAIL s%0d_accept_timeout: got no tready expected handshake", r);
        end
    endtask

    task automatic wait_drain(input string name);
        bit ok = 0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge Clk);
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && !core_busy) begin ok = 1; break; end
        end
        @(posedge Clk); #1;
        if (!ok) begin
            total++; bad++;
            $display("FAIL %s_drain_timeout: got %0d/%0d pending expected 0", name,
                     exp_q[0].size(), exp_q[1].size());
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, acc1, u0;
        bit seen;
        Rst = 1'b1; En = 1'b1;
        for (int r = 0; r < 2; r++) begin
            req_key[r] = '0; req_len[r] = '0; req_upd[r] = 1'b0;
            s_tdata[r] = '0; s_tvalid[r] = 1'b0; mkey[r] = '0; mlen[r] = '0;
        end
        repeat (3) @(posedge Clk);
        #1;
        @(negedge Clk);
        check("rst_grant", 256'(Grant), 256'(0));
        check("rst_s_tready", 256'({s_tready[0], s_tready[1]}), 256'(0));
        check("rst_m_tvalid", 256'({m_tvalid[0], m_tvalid[1]}), 256'(0));
        check("rst_cipher_handshake", 256'({cs_tvalid, cm_tready}), 256'(0));
        check("rst_key_update", 256'({CipherKeyUpdate, CipherKeyLenUpdate}), 256'(0));
        check("rst_cipher_key", CipherKey, 256'(0));
        check("rst_blockcnt", 256'({BlockCnt0, BlockCnt1}), 256'(0));
        @(posedge Clk); #1;
        Rst = 1'b0;
        repeat (2) @(posedge Clk);
        #1;

        // FIPS-197 block through requester 0
        u0 = upd_cnt; grant_log.delete();
        key_update(0, FIPS_KEY, 2'b00);
        send_block(0, FIPS_PT, acc0);
        wait_drain("fips");
        check("fips_key_swaps", 256'(upd_cnt - u0), 256'(1));
        check("fips_grant_count", 256'(grant_log.size()), 256'(1));
        if (grant_log.size() > 0) check("fips_grant", 256'(grant_log[0]), 256'(2'b01));
        check("fips_blockcnt0", 256'(BlockCnt0), exp_cnt(1));

        // Same owner, clean key: no swap
        u0 = upd_cnt;
        send_block(0, FIPS_PT, acc0);
        wait_drain("second");
        check("second_no_swap", 256'(upd_cnt - u0), 256'(0));
        check("second_blockcnt0", 256'(BlockCnt0), exp_cnt(2));

        // Simultaneous requesters with different keys: alternate, swap on every switch
        key_update(0, rnd256(), 2'($urandom_range(0, 2)));
        key_update(1, rnd256(), 2'($urandom_range(0, 2)));
        u0 = upd_cnt; grant_log.delete();
        fork
            begin send_block(0, rnd128(), acc0); send_block(0, rnd128(), acc0); end
            begin send_block(1, rnd128(), acc1); send_block(1, rnd128(), acc1); end
        join
        wait_drain("rr");
        check("rr_grant_count", 256'(grant_log.size()), 256'(4));
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check("rr_grant_order", 256'(grant_log[i]), 256'((i % 2 == 0) ? 2'b10 : 2'b01));
        check("rr_key_swaps", 256'(upd_cnt - u0), 256'(4));
        check("rr_blockcnt1", 256'(BlockCnt1), exp_cnt(2));

        // Key update while a block is in flight
        u0 = upd_cnt;
        send_block(0, rnd128(), acc0);
        seen = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge Clk);
            if (m_tvalid[0]) begin seen = 1; break; end
        end
        check("midblock_recv_seen", 256'(seen), 256'(1));
        @(posedge Clk); #1;
        key_update(0, rnd256(), 2'($urandom_range(0, 2)));
        wait_drain("midblock_a");
        send_block(0, rnd128(), acc0);
        wait_drain("midblock_b");
        check("midblock_swaps", 256'(upd_cnt - u0), 256'(1));

        // Random output backpressure; requester 1 waits behind requester 0's last byte
        rand_ready = 1'b1;
        for (int it = 0; it < 4; it++) begin
            if ($urandom_range(0, 1) == 1) key_update(it % 2, rnd256(), 2'($urandom_range(0, 2)));
            send_block(0, rnd128(), acc0);
            send_block(1, rnd128(), acc1);
            wait_drain("bp");
            check("bp_s1_after_m0_tlast", 256'(acc1 > last_cyc[0]), 256'(1));
        end
        rand_ready = 1'b0;

        // Reset in the middle of a block
        key_update(0, rnd256(), 2'b10);
        send_block(0, rnd128(), acc0);
        seen = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge Clk);
            if (idx[0] >= 7) begin seen = 1; break; end
        end
        check("rst_mid_bytes_seen", 256'(seen), 256'(1));
        @(posedge Clk); #1;
        Rst = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        check("rstmid_grant", 256'(Grant), 256'(0));
        check("rstmid_m0", 256'({m_tvalid[0], m_tlast[0], m_tdata[0]}), 256'(0));
        check("rstmid_ready", 256'({s_tready[0], s_tready[1], cm_tready, cs_tvalid}), 256'(0));
        check("rstmid_key", 256'({CipherKeyUpdate, CipherKeyLenUpdate, CipherKeyLen}), 256'(0));
        check("rstmid_cipher_key", CipherKey, 256'(0));
        check("rstmid_blockcnt", 256'({BlockCnt0, BlockCnt1}), 256'(0));
        @(posedge Clk); #1;
        Rst = 1'b0;
        mkey[0] = '0; mlen[0] = '0; mkey[1] = '0; mlen[1] = '0;
        @(posedge Clk); #1;
        u0 = upd_cnt;
        send_block(0, rnd128(), acc0);
        wait_drain("post_rst");
        check("post_rst_forced_swap", 256'(upd_cnt - u0), 256'(1));
        check("post_rst_blockcnt0", 256'(BlockCnt0), exp_cnt(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
